// File: rtl/sa_tile_ctrl.sv
// Tile sequencer for a weight-stationary systolic array: loads a weight tile,
// swaps it into the PEs, streams skewed activations, drains and signals done.
module sa_tile_ctrl #(
  parameter int ARRAY_ROWS     = 4,
  parameter int ARRAY_COLS     = 4,
  parameter int INP_DATA_WIDTH = 8,
  parameter int WGT_DATA_WIDTH = 8,
  parameter int K_WIDTH        = 16,
  parameter int OUT_LAT        = 6
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic [K_WIDTH-1:0]                       num_vec,
  output logic                                     busy,
  output logic                                     done,
  input  logic                                     wgt_valid,
  output logic                                     wgt_ready,
  input  logic [ARRAY_COLS*WGT_DATA_WIDTH-1:0]     wgt_data,
  input  logic                                     act_valid,
  output logic                                     act_ready,
  input  logic [ARRAY_ROWS*INP_DATA_WIDTH-1:0]     act_data,
  output logic                                     b_path_en,
  output logic [ARRAY_COLS*WGT_DATA_WIDTH-1:0]     b_path_data,
  output logic                                     b_en,
  output logic [ARRAY_ROWS*INP_DATA_WIDTH-1:0]     a_in_bus,
  output logic [ARRAY_COLS-1:0]                    out_valid
);

  localparam int DRAIN_LEN = ARRAY_ROWS + ARRAY_COLS + OUT_LAT;
  localparam int VLINE_LEN = OUT_LAT + ARRAY_COLS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_WSWAP,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                                r_state;
  logic [K_WIDTH-1:0]                    r_k;
  logic [K_WIDTH-1:0]                    r_cnt;
  logic [ARRAY_COLS*WGT_DATA_WIDTH-1:0]  r_bpd;
  logic [VLINE_LEN-1:0]                  r_vline;

  logic w_wgt_acc;
  logic w_act_acc;
  logic w_last_beat;
  logic w_last_vec;
  logic w_last_drain;

  assign w_wgt_acc    = (r_state == S_WLOAD) && wgt_valid;
  assign w_act_acc    = (r_state == S_STREAM) && act_valid;
  assign w_last_beat  = (r_cnt == K_WIDTH'(ARRAY_ROWS - 1));
  // Only evaluated in STREAM, where K is known to be non-zero.
  assign w_last_vec   = (r_cnt == (r_k - K_WIDTH'(1)));
  assign w_last_drain = (r_cnt == K_WIDTH'(DRAIN_LEN - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_cnt   <= '0;
      r_bpd   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_k     <= num_vec;
            r_cnt   <= '0;
            r_state <= S_WLOAD;
          end
        end
        S_WLOAD: begin
          if (wgt_valid) begin
            r_bpd <= wgt_data;
            if (w_last_beat) begin
              r_cnt   <= '0;
              r_state <= S_WSWAP;
            end else begin
              r_cnt <= r_cnt + K_WIDTH'(1);
            end
          end
        end
        S_WSWAP: begin
          r_state <= (r_k != '0) ? S_STREAM : S_DONE;
        end
        S_STREAM: begin
          if (act_valid) begin
            if (w_last_vec) begin
              r_cnt   <= '0;
              r_state <= S_DRAIN;
            end else begin
              r_cnt <= r_cnt + K_WIDTH'(1);
            end
          end
        end
        S_DRAIN: begin
          if (w_last_drain) begin
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + K_WIDTH'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign wgt_ready   = (r_state == S_WLOAD);
  assign act_ready   = (r_state == S_STREAM);
  assign b_en        = (r_state == S_WSWAP);
  assign done        = (r_state == S_DONE);
  assign b_path_en   = w_wgt_acc;
  assign b_path_data = r_bpd;

  // Row r sees its activation r+1 cycles after acceptance; bubbles push zeros.
  genvar gi;
  generate
    for (gi = 0; gi < ARRAY_ROWS; gi++) begin : g_row
      logic [INP_DATA_WIDTH-1:0] r_dly [gi+1];
      logic [INP_DATA_WIDTH-1:0] w_feed;

      assign w_feed = w_act_acc ? act_data[gi*INP_DATA_WIDTH +: INP_DATA_WIDTH] : '0;

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int j = 0; j <= gi; j++) begin
            r_dly[j] <= '0;
          end
        end else begin
          r_dly[0] <= w_feed;
          for (int j = 1; j <= gi; j++) begin
            r_dly[j] <= r_dly[j-1];
          end
        end
      end

      assign a_in_bus[gi*INP_DATA_WIDTH +: INP_DATA_WIDTH] = r_dly[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vline <= '0;
    end else begin
      r_vline <= {r_vline[VLINE_LEN-2:0], w_act_acc};
    end
  end

  // Column c result trails column 0 by c cycles.
  generate
    for (gi = 0; gi < ARRAY_COLS; gi++) begin : g_col
      assign out_valid[gi] = r_vline[OUT_LAT + gi];
    end
  endgenerate

endmodule

// File: tb/tb_sa_tile_ctrl.sv
// Bench for sa_tile_ctrl: a scripted tile timeline builds per-cycle expected
// outputs, and a negedge process compares every checked cycle.
module tb_sa_tile_ctrl;

  localparam int R    = 4;
  localparam int C    = 4;
  localparam int IW   = 8;
  localparam int WW   = 8;
  localparam int KW   = 16;
  localparam int L    = 6;
  localparam int D    = R + C + L;
  localparam int WB   = C * WW;
  localparam int AB   = R * IW;
  localparam int MAXC = 6000;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [KW-1:0] num_vec;
  logic          busy;
  logic          done;
  logic          wgt_valid;
  logic          wgt_ready;
  logic [WB-1:0] wgt_data;
  logic          act_valid;
  logic          act_ready;
  logic [AB-1:0] act_data;
  logic          b_path_en;
  logic [WB-1:0] b_path_data;
  logic          b_en;
  logic [AB-1:0] a_in_bus;
  logic [C-1:0]  out_valid;

  sa_tile_ctrl #(
    .ARRAY_ROWS(R), .ARRAY_COLS(C), .INP_DATA_WIDTH(IW),
    .WGT_DATA_WIDTH(WW), .K_WIDTH(KW), .OUT_LAT(L)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_vec(num_vec),
    .busy(busy), .done(done),
    .wgt_valid(wgt_valid), .wgt_ready(wgt_ready), .wgt_data(wgt_data),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .b_path_en(b_path_en), .b_path_data(b_path_data), .b_en(b_en),
    .a_in_bus(a_in_bus), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Expected value of every output, indexed by cycle.
  bit          exp_chk  [MAXC];
  bit          exp_busy [MAXC];
  bit          exp_wr   [MAXC];
  bit          exp_ar   [MAXC];
  bit          exp_bpen [MAXC];
  bit          exp_ben  [MAXC];
  bit          exp_done [MAXC];
  bit [WB-1:0] exp_bpd  [MAXC];
  bit [AB-1:0] exp_ain  [MAXC];
  bit [C-1:0]  exp_ov   [MAXC];

  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  bit [WB-1:0] model_bpd;
  int          wprob = 4;
  int          aprob = 4;
  bit          wpat [$];
  bit          apat [$];
  bit [WB-1:0] wq [$];
  bit [AB-1:0] aq [$];

  task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h, want %h", nm, cyc, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_exp(input bit b, input bit wr, input bit ar, input bit bpe,
                         input bit be, input bit dn);
    if (cyc < MAXC) begin
      exp_chk[cyc]  = 1'b1;
      exp_busy[cyc] = b;
      exp_wr[cyc]   = wr;
      exp_ar[cyc]   = ar;
      exp_bpen[cyc] = bpe;
      exp_ben[cyc]  = be;
      exp_done[cyc] = dn;
      exp_bpd[cyc]  = model_bpd;
    end
  endtask

  task automatic noise(input bit allow_start);
    act_data  = AB'($urandom);
    wgt_data  = WB'($urandom);
    num_vec   = KW'($urandom);
    start     = allow_start && ($urandom_range(0, 2) == 0);
    wgt_valid = 1'($urandom_range(0, 1));
    act_valid = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      noise(1'b0);
      set_exp(0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  // One tile as seen from outside: start, R weight beats, swap, K vectors,
  // D drain cycles, done. abort_at = STREAM cycle index at which reset hits.
  task automatic run_tile(input int k, input int abort_at);
    int          beats = 0;
    int          acc = 0;
    int          n = 0;
    bit [WB-1:0] wd;
    bit [AB-1:0] ad;

    noise(1'b0);
    start   = 1'b1;
    num_vec = KW'(k);
    set_exp(0, 0, 0, 0, 0, 0);
    tick();

    while (beats < R) begin
      noise(1'b1);
      if (wpat.size() > 0) wgt_valid = wpat.pop_front();
      else                 wgt_valid = ($urandom_range(1, 4) <= wprob);
      wd = (wq.size() > 0) ? wq[0] : WB'($urandom);
      wgt_data = wd;
      set_exp(1, 1, 0, wgt_valid, 0, 0);
      if (wgt_valid) begin
        if (wq.size() > 0) wq.delete(0);
        beats++;
        model_bpd = wd;
      end
      tick();
    end

    noise(1'b1);
    set_exp(1, 0, 0, 0, 1, 0);
    tick();

    if (k == 0) begin
      noise(1'b1);
      set_exp(1, 0, 0, 0, 0, 1);
      tick();
      return;
    end

    while (acc < k) begin
      noise(1'b1);
      if (n == abort_at) begin
        reset = 1'b1;
        set_exp(1, 0, 1, 0, 0, 0);
        tick();
        reset = 1'b0;
        for (int i = cyc; i < cyc + 64 && i < MAXC; i++) begin
          exp_ain[i] = '0;
          exp_ov[i]  = '0;
        end
        model_bpd = '0;
        return;
      end
      if (apat.size() > 0) act_valid = apat.pop_front();
      else                 act_valid = ($urandom_range(1, 4) <= aprob);
      ad = (aq.size() > 0) ? aq[0] : AB'($urandom);
      act_data = ad;
      set_exp(1, 0, 1, 0, 0, 0);
      if (act_valid) begin
        if (aq.size() > 0) aq.delete(0);
        for (int r = 0; r < R; r++)
          if (cyc + r + 1 < MAXC) exp_ain[cyc + r + 1][r*IW +: IW] = ad[r*IW +: IW];
        for (int c = 0; c < C; c++)
          if (cyc + L + 1 + c < MAXC) exp_ov[cyc + L + 1 + c][c] = 1'b1;
        acc++;
      end
      n++;
      tick();
    end

    for (int i = 0; i < D; i++) begin
      noise(1'b1);
      set_exp(1, 0, 0, 0, 0, 0);
      tick();
    end
    noise(1'b1);
    set_exp(1, 0, 0, 0, 0, 1);
    tick();
  endtask

  always @(negedge clk) begin
    if (cyc < MAXC && exp_chk[cyc]) begin
      cmp("busy",        64'(busy),        64'(exp_busy[cyc]));
      cmp("wgt_ready",   64'(wgt_ready),   64'(exp_wr[cyc]));
      cmp("act_ready",   64'(act_ready),   64'(exp_ar[cyc]));
      cmp("b_path_en",   64'(b_path_en),   64'(exp_bpen[cyc]));
      cmp("b_en",        64'(b_en),        64'(exp_ben[cyc]));
      cmp("done",        64'(done),        64'(exp_done[cyc]));
      cmp("b_path_data", 64'(b_path_data), 64'(exp_bpd[cyc]));
      cmp("a_in_bus",    64'(a_in_bus),    64'(exp_ain[cyc]));
      cmp("out_valid",   64'(out_valid),   64'(exp_ov[cyc]));
    end
  end

  initial begin
    int s;
    int k;
    int ab;

    reset = 1'b1; start = 1'b0; num_vec = '0;
    wgt_valid = 1'b0; wgt_data = '0; act_valid = 1'b0; act_data = '0;
    model_bpd = '0;
    tick();
    set_exp(0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    idle(3);

    // Back-to-back weights W3..W0, K=2 continuous activations.
    s = cyc;
    wpat = '{1, 1, 1, 1};
    wq   = '{32'hA3B3C3D3, 32'hA2B2C2D2, 32'hA1B1C1D1, 32'hA0B0C0D0};
    apat = '{1, 1};
    aq   = '{32'h04030201, 32'h08070605};
    run_tile(2, -1);
    cmp("pin_bpd_w3",  64'(exp_bpd[s+2]),           64'h00000000A3B3C3D3);
    cmp("pin_bpd_w0",  64'(exp_bpd[s+5]),           64'h00000000A0B0C0D0);
    cmp("pin_ben",     64'(exp_ben[s+5]),           64'd1);
    cmp("pin_ain_r0",  64'(exp_ain[s+7][7:0]),      64'd1);
    cmp("pin_ain_r3a", 64'(exp_ain[s+10][31:24]),   64'd4);
    cmp("pin_ain_r3b", 64'(exp_ain[s+11][31:24]),   64'd8);
    cmp("pin_ov_a",    64'(exp_ov[s+13]),           64'b0001);
    cmp("pin_ov_b",    64'(exp_ov[s+14]),           64'b0011);
    cmp("pin_ov_c",    64'(exp_ov[s+17]),           64'b1000);
    cmp("pin_done",    64'(exp_done[s+22]),         64'd1);
    idle(2);

    // Gapped weights 1,0,1,1,0,1 and activations 1,0,1.
    s = cyc;
    wpat = '{1, 0, 1, 1, 0, 1};
    apat = '{1, 0, 1};
    run_tile(2, -1);
    cmp("pin_gap_bpen", 64'(exp_bpen[s+2]), 64'd0);
    cmp("pin_gap_ben",  64'(exp_ben[s+7]),  64'd1);
    cmp("pin_gap_ov_a", 64'(exp_ov[s+15]),  64'b0001);
    cmp("pin_gap_ov_b", 64'(exp_ov[s+16]),  64'b0010);
    cmp("pin_gap_ov_c", 64'(exp_ov[s+17]),  64'b0101);
    cmp("pin_gap_done", 64'(exp_done[s+25]), 64'd1);
    idle(2);

    // K=0 goes from swap straight to done.
    s = cyc;
    wpat = '{1, 1, 1, 1};
    run_tile(0, -1);
    cmp("pin_k0_done", 64'(exp_done[s+6]), 64'd1);
    idle(2);

    // Largest K, aborted by reset partway through streaming.
    wpat = '{1, 1, 1, 1};
    run_tile((1 << KW) - 1, 20);
    idle(4);

    for (int t = 0; t < 40; t++) begin
      if (cyc > MAXC - 400) break;
      idle($urandom_range(0, 3));
      k  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 12);
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, k + 2) : -1;
      wprob = $urandom_range(1, 4);
      aprob = $urandom_range(1, 4);
      run_tile(k, ab);
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
